// File: rtl/wave_env.sv
// wave_env: shapes an oscillator phase into saw/square/triangle/silence and scales it by an ADSR envelope.
// Latency: sample_dv pulses two clock edges after the edge that samples phase_dv=1 (shape/env -> multiply -> output).
// Backpressure: none; one phase_dv per cycle is accepted and every tick yields exactly one sample_dv, in order.
//
// Ports:
//   clk, rst_n                   clock (rising edge) and asynchronous active-low reset
//   phase[6:0], phase_dv         oscillator phase and its one-cycle sample tick
//   wave_sel[1:0]                0 saw, 1 square, 2 triangle, 3 silence
//   gate                         note held / released
//   attack/decay/release_step    envelope increments applied per tick
//   sustain_lvl                  sustain level (tracked live while sustaining)
//   sample[7:0], sample_dv       offset-binary output (midscale 8'h80) and its qualifying pulse
//   env[7:0], env_state[2:0]     current envelope level and state (IDLE=0 .. RELEASE=4)
module wave_env (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] phase,
  input  logic       phase_dv,
  input  logic [1:0] wave_sel,
  input  logic       gate,
  input  logic [7:0] attack_step,
  input  logic [7:0] decay_step,
  input  logic [7:0] release_step,
  input  logic [7:0] sustain_lvl,
  output logic [7:0] sample,
  output logic       sample_dv,
  output logic [7:0] env,
  output logic [2:0] env_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  env_state_t  r_state;
  env_state_t  w_state_nxt;
  logic [7:0]  r_env;
  logic [7:0]  w_env_nxt;
  logic        r_gate_q;

  // stage 1 -> stage 2 -> output pipeline
  logic [7:0]  r_wave;
  logic        r_s1_vld;
  logic [7:0]  r_prod_hi;
  logic        r_s2_vld;
  logic [7:0]  r_sample;
  logic        r_sample_dv;

  logic [7:0]  w_wave;
  logic        w_gate_rise;
  logic [8:0]  w_att_sum;
  logic [8:0]  w_dec_diff;
  logic [8:0]  w_rel_diff;
  logic [8:0]  w_s;
  logic [17:0] w_mul_a;
  logic [17:0] w_mul_b;
  logic [17:0] w_prod;
  logic        w_unused;

  // ---------------- stage 1: waveform shaping ----------------
  always_comb begin
    w_wave = 8'h80;
    case (wave_sel)
      2'd0:    w_wave = {phase, phase[6]};
      2'd1:    w_wave = phase[6] ? 8'hFF : 8'h00;
      2'd2:    w_wave = {(phase[6] ? ~phase[5:0] : phase[5:0]), 2'b00};
      default: w_wave = 8'h80;
    endcase
  end

  // ---------------- stage 1: envelope FSM ----------------
  assign w_gate_rise = gate & ~r_gate_q;
  // 9-bit arithmetic: bit 8 is the carry (attack) or borrow (decay/release)
  assign w_att_sum  = {1'b0, r_env} + {1'b0, attack_step};
  assign w_dec_diff = {1'b0, r_env} - {1'b0, decay_step};
  assign w_rel_diff = {1'b0, r_env} - {1'b0, release_step};

  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    if (w_gate_rise) begin
      // retrigger from the current level; edge wins over any step completion
      w_state_nxt = ST_ATTACK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_env_nxt = 8'h00;
        end
        ST_ATTACK: begin
          if (!gate) begin
            w_state_nxt = ST_RELEASE;
          end else if (w_att_sum[8] || (w_att_sum[7:0] == 8'hFF)) begin
            w_env_nxt   = 8'hFF;
            w_state_nxt = ST_DECAY;
          end else begin
            w_env_nxt = w_att_sum[7:0];
          end
        end
        ST_DECAY: begin
          if (!gate) begin
            w_state_nxt = ST_RELEASE;
          end else if (w_dec_diff[8] || (w_dec_diff[7:0] <= sustain_lvl)) begin
            w_env_nxt   = sustain_lvl;
            w_state_nxt = ST_SUSTAIN;
          end else begin
            w_env_nxt = w_dec_diff[7:0];
          end
        end
        ST_SUSTAIN: begin
          if (!gate) begin
            w_state_nxt = ST_RELEASE;
          end else begin
            w_env_nxt = sustain_lvl;
          end
        end
        ST_RELEASE: begin
          if (w_rel_diff[8] || (w_rel_diff[7:0] == 8'h00)) begin
            w_env_nxt   = 8'h00;
            w_state_nxt = ST_IDLE;
          end else begin
            w_env_nxt = w_rel_diff[7:0];
          end
        end
        default: begin
          w_env_nxt   = 8'h00;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_env    <= 8'h00;
      r_gate_q <= 1'b0;
      r_wave   <= 8'h00;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= phase_dv;
      if (phase_dv) begin
        r_state  <= w_state_nxt;
        r_env    <= w_env_nxt;
        r_gate_q <= gate;
        r_wave   <= w_wave;
      end
    end
  end

  // ---------------- stage 2: signed scale by envelope ----------------
  // s = wave - 128 as 9-bit two's complement; operands sign/zero-extended to
  // 18 bits so the unsigned multiply yields the signed product modulo 2^18.
  assign w_s     = {1'b0, r_wave} - 9'd128;
  assign w_mul_a = {{9{w_s[8]}}, w_s};
  assign w_mul_b = {10'd0, r_env};
  assign w_prod  = w_mul_a * w_mul_b;
  // prod >>> 8 fits in [-128, 126]; its low byte plus 0x80 is the offset-binary result
  assign w_unused = ^{w_prod[17:16], w_prod[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_hi <= 8'h00;
      r_s2_vld  <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_prod_hi <= w_prod[15:8];
      end
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample    <= 8'h80;
      r_sample_dv <= 1'b0;
    end else begin
      r_sample_dv <= r_s2_vld;
      if (r_s2_vld) begin
        r_sample <= r_prod_hi + 8'h80;
      end
    end
  end

  assign sample    = r_sample;
  assign sample_dv = r_sample_dv;
  assign env       = r_env;
  assign env_state = r_state;

endmodule

// File: tb/tb_wave_env.sv
module tb_wave_env;

  logic       clk;
  logic       rst_n;
  logic [6:0] phase;
  logic       phase_dv;
  logic [1:0] wave_sel;
  logic       gate;
  logic [7:0] attack_step;
  logic [7:0] decay_step;
  logic [7:0] release_step;
  logic [7:0] sustain_lvl;
  logic [7:0] sample;
  logic       sample_dv;
  logic [7:0] env;
  logic [2:0] env_state;

  int n_chk;
  int n_fail;

  wave_env dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .phase        (phase),
    .phase_dv     (phase_dv),
    .wave_sel     (wave_sel),
    .gate         (gate),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .release_step (release_step),
    .sustain_lvl  (sustain_lvl),
    .sample       (sample),
    .sample_dv    (sample_dv),
    .env          (env),
    .env_state    (env_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       gate;
    logic [7:0] atk;
    logic [7:0] dec;
    logic [7:0] rel;
    logic [7:0] sus;
    logic [1:0] sel;
    logic [6:0] ph;
    logic [7:0] exp_env;
    logic [2:0] exp_st;
    logic [7:0] exp_smp;
  } vec_t;

  localparam int NVEC = 23;
  vec_t       vecs [NVEC];
  logic [7:0] burst_exp [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;

    //            gate  atk     dec     rel      sus      sel   ph      env      st    sample
    vecs[0]  = '{1'b1, 8'd255, 8'd16,  8'd40,  8'd200, 2'd0, 7'h7F, 8'd0,   3'd1, 8'd128};
    vecs[1]  = '{1'b1, 8'd255, 8'd16,  8'd40,  8'd200, 2'd0, 7'h7F, 8'd255, 3'd2, 8'd254};
    vecs[2]  = '{1'b1, 8'd255, 8'd16,  8'd40,  8'd200, 2'd1, 7'h7F, 8'd239, 3'd2, 8'd246};
    vecs[3]  = '{1'b1, 8'd255, 8'd16,  8'd40,  8'd200, 2'd1, 7'h00, 8'd223, 3'd2, 8'd16};
    vecs[4]  = '{1'b1, 8'd255, 8'd16,  8'd40,  8'd200, 2'd2, 7'h10, 8'd207, 3'd2, 8'd76};
    vecs[5]  = '{1'b1, 8'd255, 8'd16,  8'd40,  8'd200, 2'd2, 7'h50, 8'd200, 3'd3, 8'd174};
    vecs[6]  = '{1'b1, 8'd255, 8'd16,  8'd40,  8'd100, 2'd3, 7'h00, 8'd100, 3'd3, 8'd128};
    vecs[7]  = '{1'b0, 8'd255, 8'd16,  8'd40,  8'd100, 2'd0, 7'h40, 8'd100, 3'd4, 8'd128};
    vecs[8]  = '{1'b0, 8'd255, 8'd16,  8'd40,  8'd100, 2'd0, 7'h3F, 8'd60,  3'd4, 8'd127};
    vecs[9]  = '{1'b1, 8'd50,  8'd16,  8'd40,  8'd100, 2'd0, 7'h00, 8'd60,  3'd1, 8'd98};
    vecs[10] = '{1'b1, 8'd50,  8'd16,  8'd40,  8'd100, 2'd0, 7'h7F, 8'd110, 3'd1, 8'd182};
    vecs[11] = '{1'b0, 8'd50,  8'd16,  8'd40,  8'd100, 2'd0, 7'h7F, 8'd110, 3'd4, 8'd182};
    vecs[12] = '{1'b0, 8'd50,  8'd16,  8'd40,  8'd100, 2'd0, 7'h7F, 8'd70,  3'd4, 8'd162};
    vecs[13] = '{1'b0, 8'd50,  8'd16,  8'd40,  8'd100, 2'd0, 7'h7F, 8'd30,  3'd4, 8'd142};
    vecs[14] = '{1'b0, 8'd50,  8'd16,  8'd40,  8'd100, 2'd0, 7'h7F, 8'd0,   3'd0, 8'd128};
    vecs[15] = '{1'b0, 8'd50,  8'd16,  8'd40,  8'd100, 2'd0, 7'h7F, 8'd0,   3'd0, 8'd128};
    vecs[16] = '{1'b1, 8'd0,   8'd16,  8'd40,  8'd100, 2'd0, 7'h7F, 8'd0,   3'd1, 8'd128};
    vecs[17] = '{1'b1, 8'd0,   8'd16,  8'd40,  8'd100, 2'd0, 7'h7F, 8'd0,   3'd1, 8'd128};
    vecs[18] = '{1'b1, 8'd255, 8'd16,  8'd40,  8'd100, 2'd0, 7'h7F, 8'd255, 3'd2, 8'd254};
    vecs[19] = '{1'b0, 8'd255, 8'd16,  8'd255, 8'd100, 2'd0, 7'h7F, 8'd255, 3'd4, 8'd254};
    vecs[20] = '{1'b1, 8'd1,   8'd16,  8'd255, 8'd100, 2'd0, 7'h7F, 8'd255, 3'd1, 8'd254};
    vecs[21] = '{1'b1, 8'd1,   8'd16,  8'd255, 8'd100, 2'd0, 7'h7F, 8'd255, 3'd2, 8'd254};
    vecs[22] = '{1'b1, 8'd1,   8'd255, 8'd255, 8'd100, 2'd0, 7'h7F, 8'd100, 3'd3, 8'd177};

    // triangle, phases 0,8,..,56 at a steady sustained env of 100
    burst_exp[0] = 8'd78;  burst_exp[1] = 8'd90;  burst_exp[2] = 8'd103; burst_exp[3] = 8'd115;
    burst_exp[4] = 8'd128; burst_exp[5] = 8'd140; burst_exp[6] = 8'd153; burst_exp[7] = 8'd165;

    rst_n = 1'b0;
    phase = 7'd0;
    phase_dv = 1'b0;
    wave_sel = 2'd0;
    gate = 1'b0;
    attack_step = 8'd0;
    decay_step = 8'd0;
    release_step = 8'd0;
    sustain_lvl = 8'd0;

    // ---- reset values, then 20 idle cycles ----
    #12;
    chk("rst_sample", 32'(sample), 32'h80);
    chk("rst_dv", 32'(sample_dv), 32'd0);
    chk("rst_env", 32'(env), 32'd0);
    chk("rst_state", 32'(env_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_dv[%0d]", c), 32'(sample_dv), 32'd0);
    end
    chk("idle_sample", 32'(sample), 32'h80);
    chk("idle_state", 32'(env_state), 32'd0);
    chk("idle_env", 32'(env), 32'd0);

    // ---- table-driven single ticks ----
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      gate = vecs[i].gate;
      attack_step = vecs[i].atk;
      decay_step = vecs[i].dec;
      release_step = vecs[i].rel;
      sustain_lvl = vecs[i].sus;
      wave_sel = vecs[i].sel;
      phase = vecs[i].ph;
      phase_dv = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_env", i), 32'(env), 32'(vecs[i].exp_env));
      chk($sformatf("v%0d_state", i), 32'(env_state), 32'(vecs[i].exp_st));
      chk($sformatf("v%0d_dv_e0", i), 32'(sample_dv), 32'd0);
      @(negedge clk);
      phase_dv = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_dv_e1", i), 32'(sample_dv), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_dv_e2", i), 32'(sample_dv), 32'd1);
      chk($sformatf("v%0d_sample", i), 32'(sample), 32'(vecs[i].exp_smp));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_dv_e3", i), 32'(sample_dv), 32'd0);
      chk($sformatf("v%0d_hold", i), 32'(sample), 32'(vecs[i].exp_smp));
    end

    // ---- back-to-back burst of 8 ticks ----
    wave_sel = 2'd2;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < 8) begin
        phase = 7'(k * 8);
        phase_dv = 1'b1;
      end else begin
        phase_dv = 1'b0;
      end
      @(posedge clk);
      #1;
      if (k >= 2 && k <= 9) begin
        chk($sformatf("burst_dv[%0d]", k), 32'(sample_dv), 32'd1);
        chk($sformatf("burst_sample[%0d]", k), 32'(sample), 32'(burst_exp[k-2]));
      end else begin
        chk($sformatf("burst_dv[%0d]", k), 32'(sample_dv), 32'd0);
      end
    end
    chk("burst_env", 32'(env), 32'd100);
    chk("burst_state", 32'(env_state), 32'd3);

    // ---- burst interrupted by reset ----
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      phase = 7'(k * 8);
      phase_dv = 1'b1;
      @(posedge clk);
      #1;
      if (k >= 2) begin
        chk($sformatf("rburst_dv[%0d]", k), 32'(sample_dv), 32'd1);
        chk($sformatf("rburst_sample[%0d]", k), 32'(sample), 32'(burst_exp[k-2]));
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    phase_dv = 1'b0;
    #1;
    chk("mid_rst_sample", 32'(sample), 32'h80);
    chk("mid_rst_dv", 32'(sample_dv), 32'd0);
    chk("mid_rst_env", 32'(env), 32'd0);
    chk("mid_rst_state", 32'(env_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_dv[%0d]", c), 32'(sample_dv), 32'd0);
    end
    chk("post_rst_sample", 32'(sample), 32'h80);

    // first tick after reset: gate still high, gate_q cleared -> retrigger
    @(negedge clk);
    phase = 7'd0;
    phase_dv = 1'b1;
    @(posedge clk);
    #1;
    chk("new_tick_state", 32'(env_state), 32'd1);
    chk("new_tick_env", 32'(env), 32'd0);
    @(negedge clk);
    phase_dv = 1'b0;
    @(posedge clk);
    #1;
    chk("new_tick_dv_e1", 32'(sample_dv), 32'd0);
    @(posedge clk);
    #1;
    chk("new_tick_dv_e2", 32'(sample_dv), 32'd1);
    chk("new_tick_sample", 32'(sample), 32'd128);
    @(posedge clk);
    #1;
    chk("new_tick_dv_e3", 32'(sample_dv), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
